// File: rtl/pipe_stage_chain.sv
// Chain of DEPTH valid/ready pipeline stages, each with a one-entry skid buffer,
// carrying a data payload and a control field that is zeroed on flush or when invalid.
module pipe_stage_chain #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 12,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = 5
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_bubble,
  output logic [CNT_W-1:0]  occupancy
);

  // Per-stage main-register view and registered ready, indexed by stage
  logic [DEPTH-1:0]  st_valid;
  logic [DEPTH-1:0]  st_ready;
  logic [DATA_W-1:0] st_data [DEPTH];
  logic [CTRL_W-1:0] st_ctrl [DEPTH];

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic              up_valid;
    logic [DATA_W-1:0] up_data;
    logic [CTRL_W-1:0] up_ctrl;
    logic              dn_ready;

    logic              m_valid, m_valid_n;
    logic [DATA_W-1:0] m_data,  m_data_n;
    logic [CTRL_W-1:0] m_ctrl,  m_ctrl_n;
    logic              s_valid, s_valid_n;
    logic [DATA_W-1:0] s_data,  s_data_n;
    logic [CTRL_W-1:0] s_ctrl,  s_ctrl_n;
    logic              rdy_q;
    logic              take;
    logic              pop;

    if (k == 0) begin : g_head
      assign up_valid = in_valid;
      assign up_data  = in_data;
      assign up_ctrl  = in_ctrl;
    end else begin : g_link
      assign up_valid = st_valid[k-1];
      assign up_data  = st_data[k-1];
      assign up_ctrl  = st_ctrl[k-1];
    end

    if (k == DEPTH - 1) begin : g_tail
      assign dn_ready = out_ready;
    end else begin : g_mid
      assign dn_ready = st_ready[k+1];
    end

    assign take = up_valid & rdy_q;
    assign pop  = m_valid & dn_ready;

    always_comb begin
      m_valid_n = m_valid;
      m_data_n  = m_data;
      m_ctrl_n  = m_ctrl;
      s_valid_n = s_valid;
      s_data_n  = s_data;
      s_ctrl_n  = s_ctrl;
      if (flush) begin
        // Data is deliberately left in place; only valid and control are killed
        m_valid_n = 1'b0;
        m_ctrl_n  = '0;
        s_valid_n = 1'b0;
        s_ctrl_n  = '0;
      end else if (pop) begin
        if (s_valid) begin
          m_valid_n = 1'b1;
          m_data_n  = s_data;
          m_ctrl_n  = s_ctrl;
          s_valid_n = 1'b0;
          s_ctrl_n  = '0;
        end else if (take) begin
          m_valid_n = 1'b1;
          m_data_n  = up_data;
          m_ctrl_n  = up_ctrl;
        end else begin
          m_valid_n = 1'b0;
          m_ctrl_n  = '0;
        end
      end else if (take) begin
        if (!m_valid) begin
          m_valid_n = 1'b1;
          m_data_n  = up_data;
          m_ctrl_n  = up_ctrl;
        end else begin
          s_valid_n = 1'b1;
          s_data_n  = up_data;
          s_ctrl_n  = up_ctrl;
        end
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        m_valid <= 1'b0;
        m_data  <= '0;
        m_ctrl  <= '0;
        s_valid <= 1'b0;
        s_data  <= '0;
        s_ctrl  <= '0;
        rdy_q   <= 1'b0;
      end else begin
        m_valid <= m_valid_n;
        m_data  <= m_data_n;
        m_ctrl  <= m_ctrl_n;
        s_valid <= s_valid_n;
        s_data  <= s_data_n;
        s_ctrl  <= s_ctrl_n;
        // Ready tracks the next skid state so it never sees out_ready combinationally
        rdy_q   <= !s_valid_n;
      end
    end

    assign st_valid[k] = m_valid;
    assign st_data[k]  = m_data;
    assign st_ctrl[k]  = m_ctrl;
    assign st_ready[k] = rdy_q;
  end

  logic             accept;
  logic             deliver;
  logic [CNT_W-1:0] occ_q;

  assign accept  = in_valid & st_ready[0];
  assign deliver = st_valid[DEPTH-1] & out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      occ_q <= '0;
    end else if (flush) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_q + CNT_W'(accept) - CNT_W'(deliver);
    end
  end

  assign in_ready   = st_ready[0];
  assign out_valid  = st_valid[DEPTH-1];
  assign out_data   = st_data[DEPTH-1];
  assign out_ctrl   = st_ctrl[DEPTH-1] & {CTRL_W{st_valid[DEPTH-1]}};
  assign out_bubble = !st_valid[DEPTH-1];
  assign occupancy  = occ_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Self-checking bench for pipe_stage_chain: directed scenarios plus a randomized
// stall run against a FIFO reference model of the chain contents.
module tb_pipe_stage_chain;
  localparam int unsigned DATA_W = 128;
  localparam int unsigned CTRL_W = 12;
  localparam int unsigned DEPTH  = 3;
  localparam int unsigned CNT_W  = 5;

  logic              clock;
  logic              resetn;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_bubble;
  logic [CNT_W-1:0]  occupancy;

  pipe_stage_chain #(
    .DATA_W(DATA_W),
    .CTRL_W(CTRL_W),
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) dut (
    .clock     (clock),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_ctrl   (in_ctrl),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ctrl  (out_ctrl),
    .out_bubble(out_bubble),
    .occupancy (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic [CTRL_W-1:0] c;
  } ent_t;

  ent_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   ncyc   = 0;
  bit   last_acc;
  bit   last_del;

  function automatic logic [DATA_W-1:0] rand_data();
    return DATA_W'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  // Advance one clock: the reference queue follows the handshake seen before the edge
  task automatic step();
    ent_t e;
    last_acc = in_valid && in_ready;
    last_del = out_valid && out_ready;
    if (!resetn || flush) begin
      q.delete();
    end else begin
      if (last_del && q.size() > 0) void'(q.pop_front());
      if (last_acc) begin
        e.d = in_data;
        e.c = in_ctrl;
        q.push_back(e);
      end
    end
    @(posedge clock);
    ncyc++;
    @(negedge clock);
  endtask

  task automatic test_reset();
    resetn = 1'b1; in_valid = 1'b0; in_data = '0; in_ctrl = '0; flush = 1'b0; out_ready = 1'b1;
    #1 resetn = 1'b0;
    in_valid = 1'b1; in_ctrl = '1; in_data = rand_data();
    @(negedge clock);
    repeat (3) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl got=%h exp=0", out_ctrl); end
      checks++; if (out_bubble !== 1'b1) begin errors++; $display("FAIL reset_out_bubble got=%b exp=1", out_bubble); end
      checks++; if (occupancy !== '0) begin errors++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    end
    in_valid = 1'b0;
    resetn = 1'b1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL release_in_ready_pre got=%b exp=0", in_ready); end
    step();
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL release_occupancy got=%0d exp=0", occupancy); end
  endtask

  task automatic test_streaming();
    int idx = 0;
    int next_out = 1;
    int first_acc = -1;
    int first_valid = -1;
    out_ready = 1'b1;
    for (int n = 0; n < 80 && next_out <= 10; n++) begin
      in_valid = (idx < 10);
      in_data  = DATA_W'(idx + 1);
      in_ctrl  = 12'h0A5;
      step();
      if (last_acc) begin
        if (first_acc < 0) first_acc = ncyc;
        idx++;
      end
      if (next_out > 1) begin
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_gap got=%b exp=1 item=%0d", out_valid, next_out); end
      end
      if (out_valid === 1'b1) begin
        if (first_valid < 0) first_valid = ncyc;
        checks++; if (out_data !== DATA_W'(next_out)) begin errors++; $display("FAIL stream_data got=%0d exp=%0d", out_data, next_out); end
        checks++; if (out_ctrl !== 12'h0A5) begin errors++; $display("FAIL stream_ctrl got=%h exp=0a5", out_ctrl); end
        if (last_acc) begin
          checks++; if (occupancy !== CNT_W'(DEPTH)) begin errors++; $display("FAIL stream_occupancy got=%0d exp=%0d", occupancy, DEPTH); end
        end
        next_out++;
      end
    end
    in_valid = 1'b0;
    checks++; if (next_out != 11) begin errors++; $display("FAIL stream_complete got=%0d exp=11", next_out - 1); end
    checks++; if (first_valid - first_acc != int'(DEPTH) - 1) begin
      errors++; $display("FAIL stream_latency got=%0d exp=%0d", first_valid - first_acc + 1, DEPTH);
    end
    step();
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL stream_drained got=%0d exp=0", occupancy); end
  endtask

  task automatic test_backpressure();
    int k = 0;
    int next_out = 100;
    out_ready = 1'b0;
    for (int n = 0; n < 4 * int'(DEPTH) + 4; n++) begin
      in_valid = 1'b1;
      in_data  = DATA_W'(100 + k);
      in_ctrl  = CTRL_W'(k);
      step();
      if (last_acc) k++;
    end
    checks++; if (k != 2 * int'(DEPTH)) begin errors++; $display("FAIL bp_accepted got=%0d exp=%0d", k, 2 * DEPTH); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%b exp=0", in_ready); end
    checks++; if (occupancy !== CNT_W'(2 * DEPTH)) begin errors++; $display("FAIL bp_occupancy got=%0d exp=%0d", occupancy, 2 * DEPTH); end
    checks++; if (out_data !== DATA_W'(100)) begin errors++; $display("FAIL bp_head got=%0d exp=100", out_data); end
    out_ready = 1'b1;
    for (int n = 0; n < 4 * int'(DEPTH) + 8; n++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(next_out)) begin
        errors++; $display("FAIL bp_sequence got=%0d valid=%b exp=%0d", out_data, out_valid, next_out);
      end
      checks++; if (out_ctrl !== CTRL_W'(next_out - 100)) begin errors++; $display("FAIL bp_ctrl got=%h exp=%h", out_ctrl, CTRL_W'(next_out - 100)); end
      next_out++;
      in_valid = 1'b1;
      in_data  = DATA_W'(100 + k);
      in_ctrl  = CTRL_W'(k);
      step();
      if (last_acc) k++;
    end
    in_valid = 1'b0;
    for (int n = 0; n < 4 * int'(DEPTH) + 8 && q.size() > 0; n++) step();
    checks++; if (q.size() != 0 || out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain got=%0d exp=0", q.size()); end
  endtask

  task automatic test_flush();
    int acc = 0;
    logic [DATA_W-1:0] held;
    out_ready = 1'b0;
    for (int n = 0; n < 20 && acc < 3; n++) begin
      in_valid = 1'b1;
      in_data  = rand_data();
      in_ctrl  = CTRL_W'($urandom) | CTRL_W'(1);
      step();
      if (last_acc) acc++;
    end
    in_valid = 1'b0;
    step();
    checks++; if (occupancy !== CNT_W'(3)) begin errors++; $display("FAIL flush_pre_occupancy got=%0d exp=3", occupancy); end
    held = out_data;
    flush = 1'b1; in_valid = 1'b1; in_data = DATA_W'(8'h55); in_ctrl = '1; out_ready = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL flush_occupancy got=%0d exp=0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid got=%b exp=0", out_valid); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL flush_out_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (out_bubble !== 1'b1) begin errors++; $display("FAIL flush_bubble got=%b exp=1", out_bubble); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_data !== held) begin errors++; $display("FAIL flush_data_kept got=%h exp=%h", out_data, held); end
    repeat (3 * DEPTH) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_leak got=%b data=%h exp=0", out_valid, out_data); end
    end
  endtask

  task automatic test_random_stall();
    int delivered = 0;
    for (int n = 0; n < 2000; n++) begin
      checks++; if (occupancy !== CNT_W'(q.size())) begin errors++; $display("FAIL rnd_occupancy cyc=%0d got=%0d exp=%0d", n, occupancy, q.size()); end
      checks++; if (out_bubble !== !out_valid) begin errors++; $display("FAIL rnd_bubble cyc=%0d got=%b exp=%b", n, out_bubble, !out_valid); end
      if (out_valid === 1'b1) begin
        checks++; if (q.size() == 0 || out_data !== q[0].d || out_ctrl !== q[0].c) begin
          errors++; $display("FAIL rnd_scoreboard cyc=%0d got=%h/%h exp=%h/%h", n, out_data, out_ctrl,
                             q.size() > 0 ? q[0].d : '0, q.size() > 0 ? q[0].c : '0);
        end
      end else begin
        checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL rnd_ctrl_gate cyc=%0d got=%h exp=0", n, out_ctrl); end
      end
      if (q.size() == 2 * DEPTH) begin
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rnd_full_ready cyc=%0d got=%b exp=0", n, in_ready); end
      end
      if (q.size() == 0) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rnd_empty_ready cyc=%0d got=%b exp=1", n, in_ready); end
      end
      if (!(in_valid && !in_ready)) begin
        in_valid = 1'($urandom_range(0, 1));
        in_data  = rand_data();
        in_ctrl  = CTRL_W'($urandom);
      end
      out_ready = 1'($urandom_range(0, 1));
      step();
      if (last_del) delivered++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 4 * int'(DEPTH) + 8 && q.size() > 0; n++) begin
      checks++; if (out_valid === 1'b1 && out_data !== q[0].d) begin errors++; $display("FAIL rnd_drain_data got=%h exp=%h", out_data, q[0].d); end
      step();
    end
    checks++; if (q.size() != 0 || occupancy !== '0 || delivered == 0) begin
      errors++; $display("FAIL rnd_drain got=%0d/%0d exp=0/0", q.size(), occupancy);
    end
  endtask

  task automatic test_async_reset();
    int acc = 0;
    bit seen;
    out_ready = 1'b0;
    for (int n = 0; n < 20 && acc < 5; n++) begin
      in_valid = 1'b1;
      in_data  = rand_data();
      in_ctrl  = '1;
      step();
      if (last_acc) acc++;
    end
    checks++; if (occupancy !== CNT_W'(5)) begin errors++; $display("FAIL areset_pre_occupancy got=%0d exp=5", occupancy); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid got=%b exp=0", out_valid); end
    checks++; if (occupancy !== '0) begin errors++; $display("FAIL areset_occupancy got=%0d exp=0", occupancy); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL areset_out_ctrl got=%h exp=0", out_ctrl); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_bubble !== 1'b1) begin errors++; $display("FAIL areset_bubble got=%b exp=1", out_bubble); end
    @(negedge clock);
    q.delete();
    resetn = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2 * DEPTH + 2) begin
      step();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL areset_stale got=%b data=%h exp=0", out_valid, out_data); end
    end
    in_valid = 1'b1; in_data = DATA_W'(16'hABC); in_ctrl = 12'h3C3;
    seen = 1'b0;
    for (int n = 0; n < 4 * int'(DEPTH) && !seen; n++) begin
      step();
      if (last_acc) in_valid = 1'b0;
      if (out_valid === 1'b1) seen = 1'b1;
    end
    checks++; if (!seen || out_data !== DATA_W'(16'hABC) || out_ctrl !== 12'h3C3) begin
      errors++; $display("FAIL areset_recover got=%h/%h valid=%b exp=abc/3c3", out_data, out_ctrl, seen);
    end
    step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_random_stall();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
